xor_stream_checksum: RTL and testbench
======================================

// Module: xor_stream_checksum
// PURPOSE
//  Parametrised, clocked successor to the 1-bit xor1 gate.
//  - Folds a valid/ready stream of WIDTH-bit words into one XOR checksum per packet
//    (a packet ends on the in_last beat).
//  - Returns the checksum word, its 1-bit parity and the packet's beat count
//    through a registered output stage that holds under backpressure.
//  - Sits between a packet source and the link/parity checker in the datapath.
// PARAMETERS
//  WIDTH  8   data word width in bits (>=1)
//  CNT_W  8   beat-counter width; count saturates at 2**CNT_W-1
//  SEED   0   WIDTH-bit initial accumulator value at packet start
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  clr        in   1      synchronous abort: discard partial packet (accumulator only)
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  in_data    in   WIDTH  input word
//  in_last    in   1      final beat of packet
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  XOR of SEED and all packet words
//  out_parity out  1      ^out_data
//  out_count  out  CNT_W  beats in packet (saturated)
//  out_ovf    out  1      beat count saturated during this packet
// BEHAVIOUR
//  Reset: acc=SEED, cnt=0, ovf=0, state=IDLE, out_valid=0, out_data=0, out_parity=0,
//    out_count=0, out_ovf=0. in_ready is 1 once reset is deasserted.
//  Beat accept: acc_beat = in_valid & in_ready.
//  in_ready = !out_valid | out_ready. Combinational; it depends only on state, not on in_valid.
//  Accumulator FSM:
//    IDLE: accept, last=0 -> acc=SEED^in_data, cnt=1, go ACCUM.
//    IDLE: accept, last=1 -> load output, stay IDLE.
//    ACCUM: accept, last=0 -> acc^=in_data, cnt=sat(cnt+1).
//    ACCUM: accept, last=1 -> load output, acc=SEED, cnt=0, ovf=0, go IDLE.
//  Load output: out_data=acc_cur^in_data, out_parity=^(acc_cur^in_data),
//    out_count=sat(cnt_cur+1), out_ovf=ovf|saturating; out_valid=1.
//    acc_cur/cnt_cur are SEED/0 in IDLE.
//  Latency: result is visible the cycle after the last beat is accepted.
//    A 1-beat packet gives out_data=SEED^in_data, out_count=1.
//  Output hold: out_* stable while out_valid & !out_ready; in_ready=0 in that case.
//  Simultaneous: out_ready & out_valid & accepted last beat -> new result replaces
//    the old one with no bubble (out_valid stays 1). out_ready with no new last -> out_valid=0.
//  Saturation: cnt stops at 2**CNT_W-1 and sets ovf. The checksum keeps accumulating.
//  clr (sync): acc=SEED, cnt=0, ovf=0, state=IDLE. The beat presented that cycle is dropped;
//    in_ready is not gated by clr. The output register is unaffected.
//  rst mid-packet or mid-hold: everything returns to its reset value immediately
//    and any pending result is lost.
//  Widths: all XOR is bitwise at WIDTH. Counter add is CNT_W+1 wide, then clamped.
// STRUCTURE
//  Shared package xor_pkg:
//    - state typedef {IDLE, ACCUM}
//    - function sat_inc(cnt, CNT_W)
//    - localparam CNT_MAX
//  One natural sub-module, xor_out_reg: the valid/ready holding register for the result
//    bundle {out_data, out_parity, out_count, out_ovf}.
//  Top level holds the FSM, accumulator and counter.
// TESTING
//  1 WIDTH=8, SEED=0, out_ready=1; one beat 8'hA5 last=1
//      -> next cycle out_data=A5, out_parity=0, out_count=1.
//  2 Packet 8'h0F,8'hF0,8'h3C (last on 3rd) -> out_data=C3, out_parity=0, out_count=3;
//      SEED=8'hFF -> out_data=3C.
//  3 Backpressure: out_ready=0 after result
//      -> in_ready=0, out_* held 5 cycles; out_ready=1 with a new 1-beat packet 8'h01
//      -> out_valid stays 1, out_data=01.
//  4 CNT_W=2, 5-beat packet of 8'h01
//      -> out_count=3, out_ovf=1, out_data=01. The next packet has out_ovf=0.
//  5 clr after 2 beats (8'h11,8'h22), then 1 beat 8'h44 last
//      -> out_data=44, out_count=1. A pending output is untouched by clr.
//  6 Assert rst mid-packet and during output hold
//      -> out_valid=0 and all outputs 0 asynchronously. After release, packet 8'h5A -> out_data=5A.

Source files
------------

// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR stream checksum block.
package xor_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    // Increment with one bit of headroom, then clamp to the cnt_w-bit maximum.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int cnt_w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, cnt} + 33'd1;
        lim = (33'd1 << cnt_w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/xor_out_reg.sv
// Valid/ready holding register for the checksum result; loads in the cycle the last beat is taken.
// Contents stay frozen while valid and not ready; upstream is stalled in that state.
module xor_out_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_parity,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_ovf,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_parity,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf,
    output logic             o_in_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_parity;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    assign o_in_ready = ~r_valid | i_ready;

    // A load always wins over a drain, so a back-to-back result leaves no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_data   <= i_data;
            r_parity <= i_parity;
            r_count  <= i_count;
            r_ovf    <= i_ovf;
        end else if (i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_parity = r_parity;
    assign o_count  = r_count;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/xor_stream_checksum.sv
// Folds a valid/ready word stream into one XOR checksum, parity and beat count per packet.
// Result appears one cycle after the last beat; in_ready drops while a result is held unread.
module xor_stream_checksum
    import xor_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = CNT_W_DEF,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] CNT_LIM = '1;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic [WIDTH-1:0] w_acc_cur;
    logic [CNT_W-1:0] w_cnt_cur;
    logic             w_ovf_cur;
    logic [WIDTH-1:0] w_fold;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_sat;
    logic             w_ovf_acc;
    logic             w_in_ready;
    logic             w_beat;
    logic             w_load;

    // IDLE always behaves as a fresh packet start, regardless of register contents.
    assign w_acc_cur = (r_state == IDLE) ? SEED : r_acc;
    assign w_cnt_cur = (r_state == IDLE) ? '0   : r_cnt;
    assign w_ovf_cur = (r_state == IDLE) ? 1'b0 : r_ovf;

    assign w_fold    = w_acc_cur ^ in_data;
    assign w_cnt_inc = CNT_W'(sat_inc(32'(w_cnt_cur), CNT_W));
    assign w_sat     = (w_cnt_cur == CNT_LIM);
    assign w_ovf_acc = w_ovf_cur | w_sat;

    // clr does not gate in_ready; the beat offered alongside it is simply discarded.
    assign w_beat   = in_valid & w_in_ready & ~clr;
    assign w_load   = w_beat & in_last;
    assign in_ready = w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = SEED;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else if (w_beat) begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (in_last) begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = SEED;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ACCUM;
                        w_acc_nxt   = w_fold;
                        w_cnt_nxt   = w_cnt_inc;
                        w_ovf_nxt   = w_ovf_acc;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= SEED;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    xor_out_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_data     (w_fold),
        .i_parity   (^w_fold),
        .i_count    (w_cnt_inc),
        .i_ovf      (w_ovf_acc),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_parity   (out_parity),
        .o_count    (out_count),
        .o_ovf      (out_ovf),
        .o_in_ready (w_in_ready)
    );

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Two instances share one stimulus stream: defaults (SEED=0, CNT_W=8) and SEED=FF with CNT_W=2.
module tb_xor_stream_checksum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       rdy0, vld0, par0, ovf0;
    logic [7:0] dat0, cnt0;
    logic       rdy1, vld1, par1, ovf1;
    logic [7:0] dat1;
    logic [1:0] cnt1;

    int errors = 0;
    int checks = 0;

    // Reference model: words of the open packet plus the expected held result.
    logic [7:0] pkt[$];
    logic       exp_vld = 1'b0;
    logic [7:0] exp_dat0, exp_dat1;
    int         exp_cnt0, exp_cnt1;
    logic       exp_ovf0, exp_ovf1;

    always #5 clk = ~clk;

    xor_stream_checksum #(.WIDTH(8), .CNT_W(8), .SEED(8'h00)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
        .out_data(dat0), .out_parity(par0), .out_count(cnt0), .out_ovf(ovf0));

    xor_stream_checksum #(.WIDTH(8), .CNT_W(2), .SEED(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
        .out_data(dat1), .out_parity(par1), .out_count(cnt1), .out_ovf(ovf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic close_packet();
        logic [7:0] x;
        int         n;
        x = 8'h00;
        foreach (pkt[i]) x = x ^ pkt[i];
        n = pkt.size();
        exp_dat0 = x;
        exp_dat1 = x ^ 8'hFF;
        exp_cnt0 = (n > 255) ? 255 : n;
        exp_ovf0 = (n > 255);
        exp_cnt1 = (n > 3) ? 3 : n;
        exp_ovf1 = (n > 3);
        exp_vld  = 1'b1;
        pkt.delete();
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid0"}, vld0, exp_vld);
        chk({tag, ".valid1"}, vld1, exp_vld);
        if (exp_vld) begin
            chk({tag, ".data0"},   dat0, exp_dat0);
            chk({tag, ".parity0"}, par0, ^exp_dat0);
            chk({tag, ".count0"},  cnt0, exp_cnt0);
            chk({tag, ".ovf0"},    ovf0, exp_ovf0);
            chk({tag, ".data1"},   dat1, exp_dat1);
            chk({tag, ".parity1"}, par1, ^exp_dat1);
            chk({tag, ".count1"},  cnt1, exp_cnt1);
            chk({tag, ".ovf1"},    ovf1, exp_ovf1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid0"}, vld0, 0);
        chk({tag, ".data0"},  dat0, 0);
        chk({tag, ".par0"},   par0, 0);
        chk({tag, ".cnt0"},   cnt0, 0);
        chk({tag, ".ovf0"},   ovf0, 0);
        chk({tag, ".valid1"}, vld1, 0);
        chk({tag, ".data1"},  dat1, 0);
        chk({tag, ".cnt1"},   cnt1, 0);
        chk({tag, ".ovf1"},   ovf1, 0);
    endtask

    // One clock: drive at edge+1, check in_ready, update model, check outputs at next edge+1.
    task automatic cyc(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic c, input logic r);
        logic rdy, acc;
        in_valid = v; in_data = d; in_last = l; clr = c; out_ready = r;
        #1;
        rdy = !exp_vld || r;
        chk({tag, ".in_ready0"}, rdy0, rdy);
        chk({tag, ".in_ready1"}, rdy1, rdy);
        acc = v && rdy && !c;
        if (c) pkt.delete();
        if (acc) pkt.push_back(d);
        if (acc && l) close_packet();
        else if (r) exp_vld = 1'b0;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic send_pkt(input string tag, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(tag, 1'b1, 8'($urandom), (i == n - 1), 1'b0, r);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Single-beat packet
        cyc("one_beat", 1, 8'hA5, 1, 0, 1);
        chk("one_beat.literal", dat0, 8'hA5);
        cyc("idle", 0, 8'h00, 0, 0, 1);

        // Three-beat packet, both seeds
        cyc("three", 1, 8'h0F, 0, 0, 1);
        cyc("three", 1, 8'hF0, 0, 0, 1);
        cyc("three", 1, 8'h3C, 1, 0, 1);
        chk("three.literal0", dat0, 8'hC3);
        chk("three.literal1", dat1, 8'h3C);

        // Backpressure: hold five cycles, then replace with no bubble
        cyc("bp_load", 1, 8'h77, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc("bp_hold", 1, 8'(i + 1), 1, 0, 0);
        cyc("bp_swap", 1, 8'h01, 1, 0, 1);
        chk("bp_swap.literal", dat0, 8'h01);
        cyc("bp_drain", 0, 8'h00, 0, 0, 1);

        // Saturation boundaries: CNT_W=2 around 3/4/5 beats, CNT_W=8 around 255/256
        for (int i = 0; i < 5; i++) cyc("sat5", 1, 8'h01, (i == 4), 0, 1);
        chk("sat5.literal_cnt1", cnt1, 2'd3);
        chk("sat5.literal_ovf1", ovf1, 1'b1);
        send_pkt("after_sat", 1, 1);
        send_pkt("len3", 3, 1);
        send_pkt("len4", 4, 1);
        send_pkt("len255", 255, 1);
        send_pkt("len256", 256, 1);
        send_pkt("len300", 300, 1);
        send_pkt("after_long", 2, 1);

        // clr drops the partial packet and the beat offered with it; held output survives
        cyc("clr", 1, 8'h11, 0, 0, 1);
        cyc("clr", 1, 8'h22, 0, 0, 1);
        cyc("clr", 1, 8'h99, 0, 1, 1);
        cyc("clr", 1, 8'h44, 1, 0, 0);
        chk("clr.literal", dat0, 8'h44);
        cyc("clr_pend", 1, 8'h55, 0, 0, 0);
        cyc("clr_pend", 1, 8'h66, 0, 1, 0);
        cyc("clr_pend", 0, 8'h00, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cyc("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 2) != 0));
        cyc("rand_end", 0, 8'h00, 0, 0, 1);

        // Asynchronous reset mid-packet
        cyc("rst_mid", 1, 8'h12, 0, 0, 1);
        cyc("rst_mid", 1, 8'h34, 0, 0, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("rst_mid.async");
        pkt.delete(); exp_vld = 1'b0;
        @(posedge clk); #1;
        check_zero("rst_mid.held");
        rst = 1'b0;
        cyc("rst_mid.after", 1, 8'h5A, 1, 0, 1);
        chk("rst_mid.literal", dat0, 8'h5A);

        // Asynchronous reset while a result is held
        cyc("rst_hold", 1, 8'h99, 1, 0, 0);
        cyc("rst_hold", 0, 8'h00, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_zero("rst_hold.async");
        pkt.delete(); exp_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("rst_hold.after", 1, 8'h5A, 1, 0, 1);
        chk("rst_hold.literal1", dat1, 8'hA5);
        cyc("final", 0, 8'h00, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
